parking_input_conditioner: RTL and testbench

PARKING_INPUT_CONDITIONER -- requirements
Module: parking_input_conditioner

---
 rtl/parking_pkg.sv | 26 ++
 rtl/parking_debounce.sv | 104 ++++++++++
 rtl/parking_input_conditioner.sv | 123 ++++++++++++
 tb/tb_parking_input_conditioner.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared constants, debounce state encoding and selection helper for the parking input conditioner.
// The PARKING_DEBOUNCE_EN macro (used in parking_debounce) selects full debouncing.
package parking_pkg;

    localparam logic [2:0] CAR1_SEL = 3'b001;
    localparam logic [2:0] CAR2_SEL = 3'b010;
    localparam logic [2:0] CAR3_SEL = 3'b100;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

    localparam int BTN_ENTER = 0;
    localparam int BTN_EXIT  = 1;
    localparam int NUM_BTN   = 2;

    typedef enum logic [1:0] {
        DB_IDLE      = 2'd0,
        DB_ARMING    = 2'd1,
        DB_HELD      = 2'd2,
        DB_RELEASING = 2'd3
    } db_state_e;

    function automatic logic is_valid_sel(input logic [2:0] sel);
        return (sel == CAR1_SEL) || (sel == CAR2_SEL) || (sel == CAR3_SEL);
    endfunction

endpackage

// File: rtl/parking_debounce.sv
// Two-flop synchronizer plus optional debounce FSM for one push-button.
// PARKING_DEBOUNCE_EN builds the FSM/counter; otherwise a synced rising edge is accepted.
module parking_debounce
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic accepted
);

    logic [1:0] sync_q;
    logic       synced;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    assign synced = sync_q[1];

`ifdef PARKING_DEBOUNCE_EN
    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

    db_state_e     state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Strobe is decoded from the edge that moves ARMING to HELD so the top's
    // output register lands exactly on that edge (fixed latency).
    assign accepted = (state_q == DB_ARMING) && synced && (cnt_d == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= DB_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                DB_IDLE: begin
                    if (synced) begin
                        state_q <= DB_ARMING;
                        cnt_q   <= '0;
                    end
                end
                DB_ARMING: begin
                    if (!synced) begin
                        state_q <= DB_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_d == CNT_MAX) begin
                        state_q <= DB_HELD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DB_HELD: begin
                    if (!synced) begin
                        state_q <= DB_RELEASING;
                        cnt_q   <= '0;
                    end
                end
                DB_RELEASING: begin
                    if (synced) begin
                        state_q <= DB_HELD;
                        cnt_q   <= '0;
                    end else if (cnt_d == CNT_MAX) begin
                        state_q <= DB_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    state_q <= DB_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end
`else
    logic prev_q;
    logic unused_cfg;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= synced;
        end
    end

    assign accepted   = synced & ~prev_q;
    assign unused_cfg = (DEBOUNCE_CYCLES != 0);
`endif

endmodule

// File: rtl/parking_input_conditioner.sv
// Conditions entry/exit buttons and car-select switches into registered pulses and a validated selection.
// Debouncing is selected with PARKING_DEBOUNCE_EN (see parking_debounce).
module parking_input_conditioner
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_enter_raw,
    input  logic       btn_exit_raw,
    input  logic [2:0] sw_sel_raw,
    output logic       car_enter,
    output logic       car_exit,
    output logic [2:0] car_sel,
    output logic       sel_error
);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_acc;

    assign btn_raw[BTN_ENTER] = btn_enter_raw;
    assign btn_raw[BTN_EXIT]  = btn_exit_raw;

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            parking_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk      (clk),
                .reset    (reset),
                .raw      (btn_raw[gi]),
                .accepted (btn_acc[gi])
            );
        end
    endgenerate

    logic [2:0] sel_meta_q;
    logic [2:0] sel_sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_meta_q <= 3'b000;
            sel_sync_q <= 3'b000;
        end else begin
            sel_meta_q <= sw_sel_raw;
            sel_sync_q <= sel_meta_q;
        end
    end

    logic       car_enter_q, car_enter_d;
    logic       car_exit_q,  car_exit_d;
    logic [2:0] car_sel_q,   car_sel_d;
    logic       sel_error_q, sel_error_d;
    logic       pend_q,      pend_d;
    logic [2:0] pend_sel_q,  pend_sel_d;
    logic       sel_ok;

    assign sel_ok = is_valid_sel(sel_sync_q);

    always_comb begin
        car_enter_d = 1'b0;
        car_exit_d  = 1'b0;
        sel_error_d = 1'b0;
        car_sel_d   = car_sel_q;
        pend_d      = pend_q;
        pend_sel_d  = pend_sel_q;

        if (pend_q) begin
            car_exit_d = 1'b1;
            car_sel_d  = pend_sel_q;
            pend_d     = 1'b0;
        end

        if (btn_acc[BTN_ENTER]) begin
            if (sel_ok) begin
                car_enter_d = 1'b1;
                car_sel_d   = sel_sync_q;
            end else begin
                sel_error_d = 1'b1;
            end
        end

        // An exit colliding with an outgoing enter is parked one cycle with its own selection.
        if (btn_acc[BTN_EXIT]) begin
            if (sel_ok) begin
                if (car_enter_d) begin
                    pend_d     = 1'b1;
                    pend_sel_d = sel_sync_q;
                end else begin
                    car_exit_d = 1'b1;
                    car_sel_d  = sel_sync_q;
                end
            end else begin
                sel_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            car_enter_q <= 1'b0;
            car_exit_q  <= 1'b0;
            car_sel_q   <= 3'b000;
            sel_error_q <= 1'b0;
            pend_q      <= 1'b0;
            pend_sel_q  <= 3'b000;
        end else begin
            car_enter_q <= car_enter_d;
            car_exit_q  <= car_exit_d;
            car_sel_q   <= car_sel_d;
            sel_error_q <= sel_error_d;
            pend_q      <= pend_d;
            pend_sel_q  <= pend_sel_d;
        end
    end

    assign car_enter = car_enter_q;
    assign car_exit  = car_exit_q;
    assign car_sel   = car_sel_q;
    assign sel_error = sel_error_q;

endmodule

// File: tb/tb_parking_input_conditioner.sv
// Scoreboard bench: a run-length reference model predicts each output pulse; a negedge monitor checks them.
module tb_parking_input_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_enter_raw = 1'b0;
    logic       btn_exit_raw = 1'b0;
    logic [2:0] sw_sel_raw = 3'b000;
    logic       car_enter;
    logic       car_exit;
    logic [2:0] car_sel;
    logic       sel_error;

    always #5 clk = ~clk;

    parking_input_conditioner #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_enter_raw(btn_enter_raw),
        .btn_exit_raw (btn_exit_raw),
        .sw_sel_raw   (sw_sel_raw),
        .car_enter    (car_enter),
        .car_exit     (car_exit),
        .car_sel      (car_sel),
        .sel_error    (sel_error)
    );

    typedef struct {
        int         cyc;
        logic       en;
        logic       ex;
        logic       err;
        logic [2:0] sel;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_enter = 0, n_exit = 0, n_err = 0;
    logic [2:0] model_sel = 3'b000;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: synchronizer modelled as a two-sample raw history; debounce as run lengths.
    initial begin : model
        logic hist_p1 [2];
        logic hist_p2 [2];
        logic [2:0] sel_p1, sel_p2;
        int   run [2];
        logic run_val [2];
        logic held [2];
        logic prev_z [2];
        logic acc [2];
        logic z;
        logic raw_now [2];
        logic pend;
        logic [2:0] pend_sel;
        logic e_out, x_out, err_out, one_hot;
        for (int b = 0; b < 2; b++) begin
            hist_p1[b] = 0; hist_p2[b] = 0; run[b] = 0; run_val[b] = 0;
            held[b] = 0; prev_z[b] = 0;
        end
        sel_p1 = 0; sel_p2 = 0; pend = 0; pend_sel = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                for (int b = 0; b < 2; b++) begin
                    hist_p1[b] = 0; hist_p2[b] = 0; run[b] = 0; run_val[b] = 0;
                    held[b] = 0; prev_z[b] = 0;
                end
                sel_p1 = 0; sel_p2 = 0; pend = 0; pend_sel = 0;
                model_sel = 3'b000;
            end else begin
                raw_now[0] = btn_enter_raw;
                raw_now[1] = btn_exit_raw;
                for (int b = 0; b < 2; b++) begin
                    z = hist_p2[b];
                    acc[b] = 0;
`ifdef PARKING_DEBOUNCE_EN
                    if (z == run_val[b]) run[b]++;
                    else begin run_val[b] = z; run[b] = 1; end
                    if (!held[b] && run_val[b] && run[b] == D + 1) begin
                        held[b] = 1; acc[b] = 1;
                    end else if (held[b] && !run_val[b] && run[b] == D + 1) begin
                        held[b] = 0;
                    end
`else
                    acc[b] = z && !prev_z[b];
                    prev_z[b] = z;
`endif
                    hist_p2[b] = hist_p1[b];
                    hist_p1[b] = raw_now[b];
                end
                one_hot = ($countones(sel_p2) == 1);
                e_out = 0; x_out = 0; err_out = 0;
                if (pend) begin
                    x_out = 1; model_sel = pend_sel; pend = 0;
                end
                if (acc[0]) begin
                    if (one_hot) begin e_out = 1; model_sel = sel_p2; end
                    else err_out = 1;
                end
                if (acc[1]) begin
                    if (one_hot) begin
                        if (e_out) begin pend = 1; pend_sel = sel_p2; end
                        else begin x_out = 1; model_sel = sel_p2; end
                    end else err_out = 1;
                end
                if (e_out || x_out || err_out)
                    exp_q.push_back('{cyc: cyc, en: e_out, ex: x_out, err: err_out, sel: model_sel});
                sel_p2 = sel_p1;
                sel_p1 = sw_sel_raw;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            check("car_sel_track", int'(car_sel), int'(model_sel));
            if (car_enter && car_exit) check("enter_exit_overlap", 1, 0);
            n_enter += int'(car_enter);
            n_exit  += int'(car_exit);
            n_err   += int'(sel_error);
            if (car_enter || car_exit || sel_error) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {car_enter, car_exit, sel_error}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_kind", {car_enter, car_exit, sel_error}, {e.en, e.ex, e.err});
                    check("pulse_sel", int'(car_sel), int'(e.sel));
                    $display("txn cyc=%0d enter=%0b exit=%0b err=%0b sel=%03b", cyc, car_enter, car_exit, sel_error, car_sel);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                check("missed_pulse", 0, {e.en, e.ex, e.err});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        int  base_en, base_ex, base_err;
        logic [2:0] rs;
        step(3);
        check("reset_car_enter", int'(car_enter), 0);
        check("reset_car_exit", int'(car_exit), 0);
        check("reset_car_sel", int'(car_sel), 0);
        check("reset_sel_error", int'(sel_error), 0);
        reset = 1'b0;
        sw_sel_raw = 3'b001;
        step(4);

        // Scenario 1: clean press
        base_en = n_enter;
        btn_enter_raw = 1; step(10);
        btn_enter_raw = 0; step(12);
        check("s1_enter_count", n_enter - base_en, 1);
        check("s1_car_sel", int'(car_sel), 1);

        // Scenario 2: bouncing press
        base_en = n_enter;
        btn_enter_raw = 1; step(1); btn_enter_raw = 1; step(1);
        btn_enter_raw = 0; step(1); btn_enter_raw = 1; step(1);
        btn_enter_raw = 0; step(1); btn_enter_raw = 1; step(12);
        btn_enter_raw = 0; step(12);
`ifdef PARKING_DEBOUNCE_EN
        check("s2_enter_count", n_enter - base_en, 1);
`else
        check("s2_enter_count", n_enter - base_en, 3);
`endif

        // Scenario 3: invalid selection
        sw_sel_raw = 3'b111; step(4);
        base_en = n_enter; base_err = n_err;
        btn_enter_raw = 1; step(8);
        btn_enter_raw = 0; step(12);
        check("s3_enter_count", n_enter - base_en, 0);
        check("s3_err_count", n_err - base_err, 1);
        check("s3_car_sel_held", int'(car_sel), 1);

        // Scenario 4: simultaneous enter and exit
        sw_sel_raw = 3'b010; step(4);
        base_en = n_enter; base_ex = n_exit;
        btn_enter_raw = 1; btn_exit_raw = 1; step(10);
        btn_enter_raw = 0; btn_exit_raw = 0; step(12);
        check("s4_enter_count", n_enter - base_en, 1);
        check("s4_exit_count", n_exit - base_ex, 1);
        check("s4_car_sel", int'(car_sel), 2);

        // Scenario 5: reset during ARMING with button held
        base_en = n_enter;
        btn_enter_raw = 1; step(3);
        reset = 1; step(1);
        reset = 0; step(12);
        btn_enter_raw = 0; step(12);
`ifdef PARKING_DEBOUNCE_EN
        check("s5_enter_count", n_enter - base_en, 1);
`else
        check("s5_enter_count", n_enter - base_en, 2);
`endif
        sw_sel_raw = 3'b100; step(4);

        // Scenario 6: long hold, release, press again
        base_ex = n_exit;
        btn_exit_raw = 1; step(100);
        btn_exit_raw = 0; step(10);
        btn_exit_raw = 1; step(20);
        btn_exit_raw = 0; step(12);
        check("s6_exit_count", n_exit - base_ex, 2);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1; step($urandom_range(1, 2)); reset = 0;
            end
            btn_enter_raw = 1'($urandom_range(0, 1));
            btn_exit_raw  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin
                rs = 3'b001 << $urandom_range(0, 2);
                sw_sel_raw = rs;
            end else begin
                sw_sel_raw = 3'($urandom);
            end
            step($urandom_range(1, 12));
        end
        btn_enter_raw = 0; btn_exit_raw = 0; step(20);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
